// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entry PC field is sized to FETCH_ADDR_W; narrower ADDR_W builds cast into it.
package fetch_pkg;
  localparam int          FETCH_ADDR_W = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             instr;
    logic                    fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: PC register side, instruction memory side and decode side.
// id_fault exists only when FETCH_MISALIGN_CHK_EN is defined.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_current;
  logic [ADDR_W-1:0] pc_load;
  logic              pc_ena;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              id_fault;
`endif

  modport master (
    input  pc_current, redirect_valid, redirect_addr, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output pc_load, pc_ena, imem_req, imem_addr, id_valid, id_instr, id_pc
`ifdef FETCH_MISALIGN_CHK_EN
    , output id_fault
`endif
  );

  modport slave (
    output pc_current, redirect_valid, redirect_addr, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  pc_load, pc_ena, imem_req, imem_addr, id_valid, id_instr, id_pc
`ifdef FETCH_MISALIGN_CHK_EN
    , input id_fault
`endif
  );
endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetch entries with flush; head is presented combinationally.
// Flush wins over push and pop in the same cycle.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     din_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, keeps one imem request outstanding, buffers results.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned PCs into a NOP/fault entry and HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e      state_q;
  logic              pc_ena_q;
  logic              discard_q;
  logic [ADDR_W-1:0] req_pc_q;

  fetch_entry_t      push_entry, head;
  logic              buf_full, buf_empty;
  logic [CNT_W-1:0]  buf_count_unused;
  logic              aligned, misalign, req, grant, rsp, push, pop;

`ifdef FETCH_MISALIGN_CHK_EN
  assign aligned  = (bus.pc_current[1:0] == 2'b00);
  assign misalign = (state_q == ST_REQ) && !buf_full && !bus.redirect_valid && !aligned;
`else
  assign aligned  = 1'b1;
  assign misalign = 1'b0;
`endif

  assign req   = (state_q == ST_REQ) && !buf_full && !bus.redirect_valid && aligned;
  assign grant = req && bus.imem_gnt;
  assign rsp   = (state_q == ST_WAIT) && bus.imem_rvalid;
  assign push  = (rsp && !discard_q && !bus.redirect_valid) || misalign;
  assign pop   = !buf_empty && bus.id_ready;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = FETCH_ADDR_W'(req_pc_q);
    push_entry.instr = bus.imem_rdata;
    if (misalign) begin
      push_entry.pc    = FETCH_ADDR_W'(bus.pc_current);
      push_entry.instr = NOP_INSTR;
      push_entry.fault = 1'b1;
    end
  end

  // The PC register clears when disabled, so "hold" means reloading pc_current.
  always_comb begin
    bus.pc_load = bus.pc_current;
    if (bus.redirect_valid) bus.pc_load = bus.redirect_addr;
    else if (grant)         bus.pc_load = bus.pc_current + ADDR_W'(PC_STEP);
  end

  assign bus.pc_ena    = pc_ena_q;
  assign bus.imem_req  = req;
  assign bus.imem_addr = {bus.pc_current[ADDR_W-1:2], 2'b00};
  assign bus.id_valid  = !buf_empty;
  assign bus.id_instr  = head.instr;
  assign bus.id_pc     = ADDR_W'(head.pc);
`ifdef FETCH_MISALIGN_CHK_EN
  assign bus.id_fault  = head.fault;
`else
  logic fault_unused;
  assign fault_unused = head.fault;
`endif

  // IDLE: first cycle after reset | REQ: issue request | WAIT: response pending
  // HALT: misaligned PC trapped, leave only on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_ena_q  <= 1'b0;
      discard_q <= 1'b0;
      req_pc_q  <= '0;
    end else begin
      pc_ena_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (grant) begin
            req_pc_q <= bus.pc_current;
            state_q  <= ST_WAIT;
          end else if (misalign) begin
            state_q <= ST_HALT;
          end
        end
        ST_WAIT: begin
          if (rsp) begin
            discard_q <= 1'b0;
            state_q   <= ST_REQ;
          end else if (bus.redirect_valid) begin
            discard_q <= 1'b1;
          end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        ST_HALT: if (bus.redirect_valid) state_q <= ST_REQ;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .din_i   (push_entry),
    .head_o  (head),
    .count_o (buf_count_unused),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table after reset, corner sequences, random run.
// Misaligned-PC sequence is built only when FETCH_MISALIGN_CHK_EN is defined.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int BUF_DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();
  fetch_unit #(.ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // PC register: loads pc_load when enabled, clears otherwise.
  logic [31:0] pc_reg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= '0;
    else        pc_reg <= bus.pc_ena ? bus.pc_load : '0;
  end
  assign bus.pc_current = pc_reg;

  // Instruction memory: grant when enabled, respond lat cycles after the grant.
  int          lat    = 1;
  bit          gnt_en = 1'b1;
  int          pend_cnt;
  logic [31:0] pend_addr;
  assign bus.imem_gnt = bus.imem_req & gnt_en;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
      pend_cnt        <= 0;
      pend_addr       <= '0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      if (pend_cnt == 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(pend_addr);
        pend_cnt        <= 0;
      end else if (pend_cnt > 1) begin
        pend_cnt <= pend_cnt - 1;
      end
      if (bus.imem_req && bus.imem_gnt) begin
        if (lat <= 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_word(bus.imem_addr);
        end else begin
          pend_cnt  <= lat - 1;
          pend_addr <= bus.imem_addr;
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(bit rdy, bit gen, int l);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.id_ready       = rdy;
    gnt_en             = gen;
    lat                = l;
    tick();
    tick();
    check("rst_pc_ena", bus.pc_ena, 1'b0);
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_id_valid", bus.id_valid, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(string name, int budget);
    int n = 0;
    while (!bus.id_valid && n < budget) begin
      tick();
      n++;
    end
    check(name, bus.id_valid, 1'b1);
  endtask

  task automatic pulse_redirect(logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = target;
    #1;
    check("redir_pc_load", bus.pc_load, target);
    check("redir_no_req", bus.imem_req, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  typedef struct {
    bit          rdy;
    bit          exp_valid;
    logic [31:0] exp_pc;
    bit          exp_req;
    logic [31:0] exp_pcur;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          n;
    logic [31:0] exp_pc;
    int          consumed;

    // Rows are sampled just after clock edges 1..8 following reset release.
    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h4};
    vecs[2] = '{1'b1, 1'b1, 32'h0, 1'b1, 32'h4};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h8};
    vecs[4] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h8};
    vecs[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'hC};
    vecs[6] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'hC};
    vecs[7] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h10};

    do_reset(1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) begin
      bus.id_ready = vecs[i].rdy;
      tick();
      check($sformatf("tbl%0d_pc_ena", i), bus.pc_ena, 1'b1);
      check($sformatf("tbl%0d_id_valid", i), bus.id_valid, vecs[i].exp_valid);
      check($sformatf("tbl%0d_imem_req", i), bus.imem_req, vecs[i].exp_req);
      check($sformatf("tbl%0d_pc_current", i), bus.pc_current, vecs[i].exp_pcur);
      if (vecs[i].exp_valid) begin
        check($sformatf("tbl%0d_id_pc", i), bus.id_pc, vecs[i].exp_pc);
        check($sformatf("tbl%0d_id_instr", i), bus.id_instr, mem_word(vecs[i].exp_pc));
      end
      if (vecs[i].exp_req)
        check($sformatf("tbl%0d_imem_addr", i), bus.imem_addr, vecs[i].exp_pcur);
    end

    // Backpressure: two entries fill the buffer, PC is held rather than cleared.
    do_reset(1'b0, 1'b1, 1);
    repeat (10) tick();
    check("bp_id_valid", bus.id_valid, 1'b1);
    check("bp_imem_req", bus.imem_req, 1'b0);
    check("bp_pc_hold", bus.pc_load, bus.pc_current);
    check("bp_pc_value", bus.pc_current, 32'h8);
    bus.id_ready = 1'b1;
    #1;
    check("bp_head0", bus.id_pc, 32'h0);
    tick();
    check("bp_head1_valid", bus.id_valid, 1'b1);
    check("bp_head1", bus.id_pc, 32'h4);
    check("bp_head1_instr", bus.id_instr, mem_word(32'h4));
    tick();
    check("bp_only_two", bus.id_valid, 1'b0);

    // Grant withheld: request and address stay put, PC does not move.
    do_reset(1'b1, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nognt_req", bus.imem_req, 1'b1);
      check("nognt_addr", bus.imem_addr, 32'h0);
      check("nognt_pc", bus.pc_current, 32'h0);
    end
    gnt_en = 1'b1;
    wait_valid("nognt_resume_timeout", 20);
    check("nognt_resume_pc", bus.id_pc, 32'h0);

    // Redirect while waiting on 0x8 with 0x4 buffered; same-cycle pop is ignored.
    do_reset(1'b0, 1'b1, 3);
    wait_valid("redir_first_timeout", 30);
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    n = 0;
    while (!(bus.imem_req && bus.imem_gnt && bus.imem_addr == 32'h8) && n < 40) begin
      tick();
      n++;
    end
    check("redir_req8_timeout", bus.imem_addr, 32'h8);
    tick();
    check("redir_buffered4", bus.id_pc, 32'h4);
    bus.id_ready = 1'b1;
    pulse_redirect(32'h100);
    check("redir_flushed", bus.id_valid, 1'b0);
    wait_valid("redir_next_timeout", 40);
    check("redir_next_pc", bus.id_pc, 32'h100);
    check("redir_next_instr", bus.id_instr, mem_word(32'h100));

    // Reset while waiting with one entry buffered; fetch restarts at 0.
    do_reset(1'b0, 1'b1, 3);
    wait_valid("mrst_first_timeout", 30);
    tick();
    check("mrst_pre_valid", bus.id_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_id_valid", bus.id_valid, 1'b0);
    check("mrst_imem_req", bus.imem_req, 1'b0);
    check("mrst_pc_ena", bus.pc_ena, 1'b0);
    tick();
    rst_n        = 1'b1;
    bus.id_ready = 1'b1;
    wait_valid("mrst_restart_timeout", 30);
    check("mrst_restart_pc", bus.id_pc, 32'h0);
    check("mrst_restart_instr", bus.id_instr, mem_word(32'h0));

`ifdef FETCH_MISALIGN_CHK_EN
    do_reset(1'b1, 1'b1, 1);
    repeat (4) tick();
    pulse_redirect(32'h102);
    wait_valid("mis_timeout", 20);
    check("mis_pc", bus.id_pc, 32'h102);
    check("mis_fault", bus.id_fault, 1'b1);
    check("mis_instr", bus.id_instr, NOP_INSTR);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mis_halt_req", bus.imem_req, 1'b0);
      check("mis_halt_valid", bus.id_valid, 1'b0);
      check("mis_halt_pc", bus.pc_current, 32'h102);
    end
    pulse_redirect(32'h200);
    wait_valid("mis_exit_timeout", 20);
    check("mis_exit_pc", bus.id_pc, 32'h200);
    check("mis_exit_fault", bus.id_fault, 1'b0);
    check("mis_exit_instr", bus.id_instr, mem_word(32'h200));
`endif

    // Random traffic against an in-order program-stream model.
    do_reset(1'b1, 1'b1, 1);
    exp_pc   = 32'h0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      lat                = $urandom_range(1, 4);
      gnt_en             = ($urandom_range(0, 3) != 0);
      bus.id_ready       = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                         : (32'($urandom_range(0, 16383)) << 2);
      end
      #1;
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_addr;
      end else if (bus.id_valid && bus.id_ready) begin
        check("rand_id_pc", bus.id_pc, exp_pc);
        check("rand_id_instr", bus.id_instr, mem_word(exp_pc));
`ifdef FETCH_MISALIGN_CHK_EN
        check("rand_id_fault", bus.id_fault, 1'b0);
`endif
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    bus.redirect_valid = 1'b0;
    check("rand_progress", (consumed >= 200), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
